data_compare4: RTL and testbench
================================

// Module: data_compare4
// PURPOSE
//   Registered 4-bit magnitude comparator with cascade inputs, 74LS85 semantics.
//   Compares operands A and B. When they are equal, the cascade inputs from a
//   less-significant stage decide the result.
//   Several instances chain into wider comparators: oData of the low stage feeds
//   iData of the next stage.
//   The result is registered once per clock, so it is one pipeline stage in the datapath.
// PARAMETERS
//   DATA_WIDTH  4  operand width in bits; all behaviour below is written for the 4-bit default
// PORTS
//   iClk     in   1           system clock, rising-edge active
//   iRst_n   in   1           asynchronous, active-low reset
//   iData_a  in   DATA_WIDTH  operand A, unsigned
//   iData_b  in   DATA_WIDTH  operand B, unsigned
//   iData    in   3           cascade in: [2]=a>b, [1]=a<b, [0]=a=b
//   oData    out  3           result: [2]=A>B, [1]=A<B, [0]=A=B
// BEHAVIOUR
//   - Interface: one clock (iClk); reset iRst_n is asynchronous and active-low.
//   - Reset: iRst_n low forces oData=3'b000 immediately, with no clock edge needed.
//     oData holds 000 while reset is asserted.
//   - Release: the first rising iClk edge after iRst_n goes high captures a valid result.
//   - Timing: all inputs are sampled on every rising iClk edge, with no enable.
//     oData reflects the inputs present before that edge, so latency is 1 cycle.
//     Throughput is one comparison per cycle.
//   - Comparison: unsigned, performed MSB first.
//   - A>B: next oData=3'b100, regardless of iData.
//   - A<B: next oData=3'b010, regardless of iData.
//   - A==B: result follows iData, with priority given to iData[0]:
//       iData[0]=1          -> 001, whatever iData[2:1] are
//       iData=100           -> 100
//       iData=010           -> 010
//       iData=110           -> 000
//       iData=000           -> 110
//   - Outputs are never X after reset. Any illegal cascade code resolves via the
//     rules above.
//   - Chaining: a least-significant stage must tie iData=3'b001 so that equal
//     operands report A=B.
//   - Bounds: no overflow or wrap-around is possible.
//   - Extremes: A=1111,B=0000 gives 100; A=0000,B=1111 gives 010.
// TESTING
//   1. A=1000,B=0111,iData=000 -> oData=100 one edge later.
//      Swap operands (A=0111,B=1000) -> 010.
//   2. A=0100,B=0011 -> 100; A=0011,B=0100 -> 010.
//      A=0010,B=0001 -> 100; A=0001,B=0010 -> 010.
//   3. A=B=0000 with iData=100 -> 100; iData=010 -> 010; iData=001 -> 001.
//   4. A=B=1010 with iData=000 -> 110; iData=110 -> 000; iData=111 -> 001.
//   5. Latency: change inputs mid-cycle. oData must not change until the next
//      rising iClk edge, then must match the table.
//   6. Reset: with oData=100, assert iRst_n low between edges.
//      oData=000 immediately, held through edges while low.
//      After release the first edge restores the correct result.

Source files
------------

// File: rtl/data_compare4_if.sv
// Operand, cascade and result bundle for one comparator stage.
// The master drives operands and the cascade code; the slave returns the registered result.
interface data_compare4_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] iData_a;
    logic [DATA_WIDTH-1:0] iData_b;
    logic [2:0]            iData;
    logic [2:0]            oData;

    // No valid/ready: every rising clock edge samples the inputs and produces a result one edge later.
    modport master (
        output iData_a,
        output iData_b,
        output iData,
        input  oData
    );

    modport slave (
        input  iData_a,
        input  iData_b,
        input  iData,
        output oData
    );
endinterface

// File: rtl/data_compare4.sv
// Registered 4-bit magnitude comparator with 74LS85-style cascade inputs.
// Result codes are {A>B, A<B, A=B}; one register stage, no enable.
module data_compare4 #(
    parameter int DATA_WIDTH = 4
) (
    input  logic          iClk,
    input  logic          iRst_n,
    data_compare4_if.slave bus
);

    logic       a_gt_b;
    logic       a_lt_b;
    logic       found;
    logic [2:0] cascade_res;
    logic [2:0] next_res;

    // Scan from the MSB; the first differing bit decides the magnitude relation.
    always_comb begin
        a_gt_b = 1'b0;
        a_lt_b = 1'b0;
        found  = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (!found && (bus.iData_a[i] != bus.iData_b[i])) begin
                found  = 1'b1;
                a_gt_b = bus.iData_a[i];
                a_lt_b = bus.iData_b[i];
            end
        end
    end

    // Equal operands defer to the lower stage; an asserted equal-in bit wins over everything.
    always_comb begin
        cascade_res = 3'b000;
        if (bus.iData[0]) begin
            cascade_res = 3'b001;
        end else begin
            case (bus.iData[2:1])
                2'b10:   cascade_res = 3'b100;
                2'b01:   cascade_res = 3'b010;
                2'b11:   cascade_res = 3'b000;
                default: cascade_res = 3'b110;
            endcase
        end
    end

    always_comb begin
        next_res = cascade_res;
        if (a_gt_b) begin
            next_res = 3'b100;
        end else if (a_lt_b) begin
            next_res = 3'b010;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bus.oData <= 3'b000;
        end else begin
            bus.oData <= next_res;
        end
    end

endmodule

// File: tb/tb_data_compare4.sv
// Self-checking bench for data_compare4: directed table, latency, async reset
// and randomized back-to-back traffic against a behavioural model.
module tb_data_compare4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [2:0] exp_q[$];

    data_compare4_if #(.DATA_WIDTH(4)) bus ();

    data_compare4 #(.DATA_WIDTH(4)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    // {A, B, cascade, expected}
    localparam logic [13:0] VECS [14] = '{
        {4'b1000, 4'b0111, 3'b000, 3'b100},
        {4'b0111, 4'b1000, 3'b000, 3'b010},
        {4'b0100, 4'b0011, 3'b001, 3'b100},
        {4'b0011, 4'b0100, 3'b001, 3'b010},
        {4'b0010, 4'b0001, 3'b111, 3'b100},
        {4'b0001, 4'b0010, 3'b000, 3'b010},
        {4'b0000, 4'b0000, 3'b100, 3'b100},
        {4'b0000, 4'b0000, 3'b010, 3'b010},
        {4'b0000, 4'b0000, 3'b001, 3'b001},
        {4'b1010, 4'b1010, 3'b000, 3'b110},
        {4'b1010, 4'b1010, 3'b110, 3'b000},
        {4'b1010, 4'b1010, 3'b111, 3'b001},
        {4'b1111, 4'b0000, 3'b011, 3'b100},
        {4'b0000, 4'b1111, 3'b101, 3'b010}
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(input int unsigned a, input int unsigned b,
                                           input logic [2:0] c);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        if (c[0]) return 3'b001;
        case (c)
            3'b100:  return 3'b100;
            3'b010:  return 3'b010;
            3'b110:  return 3'b000;
            default: return 3'b110;
        endcase
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        @(negedge clk);
        bus.iData_a = a;
        bus.iData_b = b;
        bus.iData   = c;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.iData_a = 4'b1111;
        bus.iData_b = 4'b0000;
        bus.iData   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.oData !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 000", bus.oData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.oData !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got %b expected 100", bus.oData);
        end
    endtask

    task automatic test_directed;
        logic [13:0] v;
        for (int i = 0; i < 14; i++) begin
            v = VECS[i];
            drive(v[13:10], v[9:6], v[5:3]);
            @(posedge clk);
            #1;
            checks++;
            if (bus.oData !== v[2:0]) begin
                errors++;
                $display("FAIL directed[%0d] a=%b b=%b c=%b: got %b expected %b",
                         i, v[13:10], v[9:6], v[5:3], bus.oData, v[2:0]);
            end
        end
    endtask

    task automatic test_latency;
        drive(4'b1000, 4'b0111, 3'b000);
        @(posedge clk);
        #1;
        checks++;
        if (bus.oData !== 3'b100) begin
            errors++;
            $display("FAIL latency_setup: got %b expected 100", bus.oData);
        end
        drive(4'b0101, 4'b0101, 3'b000);
        #2;
        checks++;
        if (bus.oData !== 3'b100) begin
            errors++;
            $display("FAIL latency_hold: got %b expected 100", bus.oData);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.oData !== 3'b110) begin
            errors++;
            $display("FAIL latency_update: got %b expected 110", bus.oData);
        end
    endtask

    task automatic test_async_reset;
        drive(4'b1000, 4'b0111, 3'b000);
        @(posedge clk);
        #1;
        checks++;
        if (bus.oData !== 3'b100) begin
            errors++;
            $display("FAIL areset_setup: got %b expected 100", bus.oData);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oData !== 3'b000) begin
            errors++;
            $display("FAIL areset_immediate: got %b expected 000", bus.oData);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.oData !== 3'b000) begin
                errors++;
                $display("FAIL areset_held[%0d]: got %b expected 000", k, bus.oData);
            end
        end
        drive(4'b0011, 4'b1100, 3'b001);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.oData !== 3'b010) begin
            errors++;
            $display("FAIL areset_release: got %b expected 010", bus.oData);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] c;
        logic [2:0] exp;
        for (int i = 0; i < n; i++) begin
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
            c = 3'($urandom_range(0, 7));
            drive(a, b, c);
            exp_q.push_back(ref_cmp(a, b, c));
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (bus.oData !== exp) begin
                errors++;
                $display("FAIL random[%0d] a=%b b=%b c=%b: got %b expected %b",
                         i, a, b, c, bus.oData, exp);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_latency();
        test_async_reset();
        test_back_to_back(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
